// File: rtl/id_decode_stage_pkg.sv
// Shared decode constants: opcode/funct encodings, ALU operation codes,
// skid buffer state encoding and the decode-bundle width.
package id_decode_stage_pkg;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SR  = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_ADDI = 4'd5,
      ALU_SLLI = 4'd6,
      ALU_SRLI = 4'd7,
      ALU_SRAI = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_FULL  = 2'd2
   } sb_state_e;

   // Bundle layout, MSB first: alu_op, rs1, rs2, rd, imm, use_imm, wb_en, illegal.
   function automatic int bundle_width(input int xlen, input int reg_aw);
      return 4 + 3 * reg_aw + xlen + 3;
   endfunction

endpackage

// File: rtl/id_decode_stage_skid_buffer2.sv
// Two-entry valid/ready skid buffer: in_ready and out_valid are plain
// registers, so no combinational path links out_ready to in_ready.
module skid_buffer2
   import id_decode_stage_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   sb_state_e        state_r;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             accept_s;
   logic             drain_s;

   assign accept_s  = in_valid && in_ready_r;
   assign drain_s   = out_valid_r && out_ready;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = main_r;

   // Occupancy state machine; main_r always holds the oldest entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= SB_EMPTY;
         main_r      <= {WIDTH{1'b0}};
         skid_r      <= {WIDTH{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else if (flush) begin
         state_r     <= SB_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            SB_EMPTY: begin
               if (accept_s) begin
                  main_r      <= in_data;
                  state_r     <= SB_ONE;
                  out_valid_r <= 1'b1;
               end
               in_ready_r <= 1'b1;
            end
            SB_ONE: begin
               if (accept_s && !drain_s) begin
                  skid_r     <= in_data;
                  state_r    <= SB_FULL;
                  in_ready_r <= 1'b0;
               end else if (drain_s && !accept_s) begin
                  state_r     <= SB_EMPTY;
                  out_valid_r <= 1'b0;
               end else if (accept_s && drain_s) begin
                  main_r <= in_data;
               end
            end
            SB_FULL: begin
               if (drain_s) begin
                  main_r     <= skid_r;
                  state_r    <= SB_ONE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= SB_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, captured
// into a two-entry skid buffer that presents the registered bundle.
module id_decode_stage
   import id_decode_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        alu_op,
   output logic [REG_AW-1:0] rs1_idx,
   output logic [REG_AW-1:0] rs2_idx,
   output logic [REG_AW-1:0] rd_idx,
   output logic [XLEN-1:0]   imm,
   output logic              use_imm,
   output logic              wb_en,
   output logic              illegal
);

   localparam int BW = bundle_width(XLEN, REG_AW);

   logic [6:0]        opcode_s;
   logic [2:0]        funct3_s;
   logic [6:0]        funct7_s;
   logic [3:0]        alu_op_s;
   logic              illegal_s;
   logic              use_imm_s;
   logic              shift_s;
   logic [REG_AW-1:0] rs2_s;
   logic [XLEN-1:0]   imm_s;
   logic              wb_en_s;
   logic [BW-1:0]     bundle_in_s;
   logic [BW-1:0]     bundle_out_s;

   assign opcode_s = in_instr[6:0];
   assign funct3_s = in_instr[14:12];
   assign funct7_s = in_instr[31:25];

   // Operation decode; anything unmatched stays illegal with alu_op = ADD.
   always_comb begin
      alu_op_s  = ALU_ADD;
      illegal_s = 1'b1;
      use_imm_s = 1'b0;
      shift_s   = 1'b0;
      case (opcode_s)
         OP_R: begin
            if (funct7_s == F7_BASE) begin
               case (funct3_s)
                  F3_ADD:  begin alu_op_s = ALU_ADD; illegal_s = 1'b0; end
                  F3_AND:  begin alu_op_s = ALU_AND; illegal_s = 1'b0; end
                  F3_OR:   begin alu_op_s = ALU_OR;  illegal_s = 1'b0; end
                  F3_XOR:  begin alu_op_s = ALU_XOR; illegal_s = 1'b0; end
                  default: illegal_s = 1'b1;
               endcase
            end else if (funct7_s == F7_ALT && funct3_s == F3_ADD) begin
               alu_op_s  = ALU_SUB;
               illegal_s = 1'b0;
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_I: begin
            case (funct3_s)
               F3_ADD: begin
                  alu_op_s  = ALU_ADDI;
                  illegal_s = 1'b0;
                  use_imm_s = 1'b1;
               end
               F3_SLL: begin
                  if (funct7_s == F7_BASE) begin
                     alu_op_s  = ALU_SLLI;
                     illegal_s = 1'b0;
                     use_imm_s = 1'b1;
                     shift_s   = 1'b1;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               F3_SR: begin
                  if (funct7_s == F7_BASE) begin
                     alu_op_s  = ALU_SRLI;
                     illegal_s = 1'b0;
                     use_imm_s = 1'b1;
                     shift_s   = 1'b1;
                  end else if (funct7_s == F7_ALT) begin
                     alu_op_s  = ALU_SRAI;
                     illegal_s = 1'b0;
                     use_imm_s = 1'b1;
                     shift_s   = 1'b1;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               default: illegal_s = 1'b1;
            endcase
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // Shifts carry an unsigned shamt; every other format sign-extends imm[11:0].
   assign imm_s   = shift_s ? {{(XLEN-5){1'b0}}, in_instr[24:20]}
                            : {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign rs2_s   = (opcode_s == OP_I) ? {REG_AW{1'b0}} : in_instr[24:20];
   assign wb_en_s = !illegal_s && (in_instr[11:7] != 5'd0);

   assign bundle_in_s = {alu_op_s, in_instr[19:15], rs2_s, in_instr[11:7],
                         imm_s, use_imm_s, wb_en_s, illegal_s};

   skid_buffer2 #(
      .WIDTH (BW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (bundle_in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (bundle_out_s)
   );

   assign {alu_op, rs1_idx, rs2_idx, rd_idx, imm, use_imm, wb_en, illegal} = bundle_out_s;

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomized scoreboard bench for id_decode_stage: a rule-table reference
// model predicts each accepted instruction's bundle, a monitor checks outputs.
module tb_id_decode_stage;
   import id_decode_stage_pkg::*;

   localparam int BW = 54;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [4:0]  rd_idx;
   logic [31:0] imm;
   logic        use_imm;
   logic        wb_en;
   logic        illegal;

   logic [BW-1:0] act_bundle;
   logic [BW-1:0] sb [$];
   int            vectors;
   int            miscompares;
   logic          took;

   id_decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_op    (alu_op),
      .rs1_idx   (rs1_idx),
      .rs2_idx   (rs2_idx),
      .rd_idx    (rd_idx),
      .imm       (imm),
      .use_imm   (use_imm),
      .wb_en     (wb_en),
      .illegal   (illegal)
   );

   assign act_bundle = {alu_op, rs1_idx, rs2_idx, rd_idx, imm, use_imm, wb_en, illegal};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Supported operations as {funct7, funct3, opcode} patterns with care masks.
   localparam logic [16:0] FULL_M = 17'h1FFFF;
   localparam logic [16:0] LOW_M  = 17'h003FF;
   localparam logic [16:0] R_VAL [9] = '{
      {7'b0000000, 3'b000, 7'b0110011}, {7'b0100000, 3'b000, 7'b0110011},
      {7'b0000000, 3'b111, 7'b0110011}, {7'b0000000, 3'b110, 7'b0110011},
      {7'b0000000, 3'b100, 7'b0110011}, {7'b0000000, 3'b000, 7'b0010011},
      {7'b0000000, 3'b001, 7'b0010011}, {7'b0000000, 3'b101, 7'b0010011},
      {7'b0100000, 3'b101, 7'b0010011}};
   localparam logic [16:0] R_MASK [9] = '{FULL_M, FULL_M, FULL_M, FULL_M, FULL_M,
                                          LOW_M, FULL_M, FULL_M, FULL_M};
   localparam logic [3:0] R_OP [9] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                                       ALU_ADDI, ALU_SLLI, ALU_SRLI, ALU_SRAI};
   localparam logic R_IMM [9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic R_SHAMT [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   function automatic logic [BW-1:0] pk(input logic [3:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] d,
                                        input logic [31:0] im, input logic u,
                                        input logic w, input logic il);
      return {op, a, b, d, im, u, w, il};
   endfunction

   function automatic logic [BW-1:0] model(input logic [31:0] i);
      logic [16:0] key;
      logic        found;
      logic [3:0]  op;
      logic        uimm;
      logic        shamt;
      logic [31:0] im;
      logic [4:0]  rs2;
      key   = {i[31:25], i[14:12], i[6:0]};
      found = 1'b0;
      op    = ALU_ADD;
      uimm  = 1'b0;
      shamt = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if ((key & R_MASK[k]) == R_VAL[k]) begin
            found = 1'b1;
            op    = R_OP[k];
            uimm  = R_IMM[k];
            shamt = R_SHAMT[k];
         end
      end
      im  = shamt ? {27'd0, i[24:20]} : {{20{i[31]}}, i[31:20]};
      rs2 = (i[6:0] == 7'b0010011) ? 5'd0 : i[24:20];
      return pk(op, i[19:15], rs2, i[11:7], im, uimm,
                found && (i[11:7] != 5'd0), !found);
   endfunction

   function automatic logic [31:0] gen();
      logic [31:0] w;
      logic [16:0] v;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) begin
         v        = R_VAL[k];
         w[6:0]   = v[6:0];
         w[14:12] = v[9:7];
         if (R_MASK[k] == FULL_M) w[31:25] = v[16:10];
      end
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      return w;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Input monitor: predict the bundle for every accepted instruction.
   always @(negedge clk) begin
      logic          acc;
      logic [BW-1:0] e;
      acc = rst_n && !flush && in_valid && in_ready;
      e   = model(in_instr);
      #1;
      if (acc) sb.push_back(e);
   end

   // Output monitor: each drained bundle must match the oldest prediction.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         sb.delete();
      end else if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 64'(act_bundle), 64'hDEAD);
         end else begin
            chk("sb_bundle", 64'(act_bundle), 64'(sb.pop_front()));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string nm);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         step();
         done = took;
      end
      if (!done) chk(nm, 64'd0, 64'd1);
   endtask

   task automatic drain(input string nm);
      logic empty;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      empty     = 1'b0;
      for (int c = 0; c < 20 && !empty; c++) begin
         @(negedge clk);
         empty = !out_valid;
         @(posedge clk);
         #1;
      end
      chk(nm, 64'(empty), 64'd1);
      chk({nm, "_sb"}, 64'(sb.size()), 64'd0);
   endtask

   logic [31:0]   d_ins [9];
   logic [BW-1:0] d_exp [9];

   initial begin
      int cnt;
      int cyc;
      vectors     = 0;
      miscompares = 0;
      took        = 1'b0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = 32'd0;
      out_ready   = 1'b0;

      d_ins[0] = 32'h002081B3; d_exp[0] = pk(ALU_ADD,  5'd1, 5'd2, 5'd3, 32'h00000002, 1'b0, 1'b1, 1'b0);
      d_ins[1] = 32'h407302B3; d_exp[1] = pk(ALU_SUB,  5'd6, 5'd7, 5'd5, 32'h00000407, 1'b0, 1'b1, 1'b0);
      d_ins[2] = 32'hFFF00093; d_exp[2] = pk(ALU_ADDI, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
      d_ins[3] = 32'h4040D113; d_exp[3] = pk(ALU_SRAI, 5'd1, 5'd0, 5'd2, 32'h00000004, 1'b1, 1'b1, 1'b0);
      d_ins[4] = 32'h0000D113; d_exp[4] = pk(ALU_SRLI, 5'd1, 5'd0, 5'd2, 32'h00000000, 1'b1, 1'b1, 1'b0);
      d_ins[5] = 32'h00000033; d_exp[5] = pk(ALU_ADD,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0);
      d_ins[6] = 32'h00001033; d_exp[6] = pk(ALU_ADD,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1);
      d_ins[7] = 32'h00309093; d_exp[7] = pk(ALU_SLLI, 5'd1, 5'd0, 5'd1, 32'h00000003, 1'b1, 1'b1, 1'b0);
      d_ins[8] = 32'h0062F233; d_exp[8] = pk(ALU_AND,  5'd5, 5'd6, 5'd4, 32'h00000006, 1'b0, 1'b1, 1'b0);

      @(negedge clk);
      chk("rst_bundle", 64'(act_bundle), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed decodes, one at a time with the consumer always ready.
      for (int k = 0; k < 9; k++) begin
         in_valid  = 1'b1;
         in_instr  = d_ins[k];
         out_ready = 1'b1;
         wait_accept("dir_accept");
         in_valid = 1'b0;
         @(negedge clk);
         chk("dir_latency_valid", 64'(out_valid), 64'd1);
         chk($sformatf("dir_bundle_%0d", k), 64'(act_bundle), 64'(d_exp[k]));
         @(posedge clk);
         #1;
      end

      // Backpressure: two entries fit, the third waits for the consumer.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = d_ins[0];
      step();
      chk("bp_acc0", 64'(took), 64'd1);
      in_instr = d_ins[1];
      step();
      chk("bp_acc1", 64'(took), 64'd1);
      in_instr = d_ins[2];
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_out_held", 64'(act_bundle), 64'(d_exp[0]));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_accept("bp_accept2");
      drain("bp_drain");

      // Flush while full with a new instruction offered in the same cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = d_ins[3];
      wait_accept("fl_acc0");
      in_instr = d_ins[4];
      wait_accept("fl_acc1");
      in_instr = d_ins[5];
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = d_ins[8];
      wait_accept("fl_post_accept");
      drain("fl_drain");

      // Random traffic with occasional flushes.
      cnt = 0;
      cyc = 0;
      took = 1'b0;
      in_valid = 1'b0;
      while (cnt < 1000 && cyc < 30000) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_instr = gen();
         end
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 199) == 0);
         step();
         if (took) cnt++;
         cyc++;
      end
      chk("rand_count", 64'(cnt), 64'd1000);
      drain("rand_drain");

      // Asynchronous reset in the middle of a stalled stream.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_instr = gen();
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_bundle", 64'(act_bundle), 64'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = d_ins[1];
      wait_accept("arst_post_accept");
      drain("arst_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
